sysid_ext_qsys: RTL and testbench



---
 rtl/sysid_pkg.sv | 31 +++
 rtl/sysid_uptime.sv | 41 ++++
 rtl/sysid_ext_qsys.sv | 131 +++++++++++++
 tb/tb_sysid_ext_qsys.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared register map, capability magic and control-bit positions for the
// extended system-ID block.
package sysid_pkg;

  localparam logic [3:0] ADDR_ID        = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
  localparam logic [3:0] ADDR_CAPS      = 4'd2;
  localparam logic [3:0] ADDR_SCRATCH   = 4'd3;
  localparam logic [3:0] ADDR_CYCLE_LO  = 4'd4;
  localparam logic [3:0] ADDR_CYCLE_HI  = 4'd5;
  localparam logic [3:0] ADDR_SECONDS   = 4'd6;
  localparam logic [3:0] ADDR_CTRL      = 4'd7;
  localparam logic [3:0] ADDR_USER0     = 4'd8;

  localparam logic [15:0] CAPS_MAGIC = 16'h5100;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysid_uptime.sv
// Uptime seconds counter: prescaler divides the clock down to one tick per
// second, and the heartbeat output toggles on every tick.
module sysid_uptime
  import sysid_pkg::*;
#(
  parameter int unsigned UPTIME_DIV = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        freeze,
  output logic [31:0] seconds,
  output logic        heartbeat
);

  localparam int unsigned PW = $clog2(UPTIME_DIV);
  localparam logic [PW-1:0] TC = PW'(UPTIME_DIV - 1);

  logic [PW-1:0] prescale;

  // Clear outranks both freeze and the terminal-count rollover.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescale  <= '0;
      seconds   <= '0;
      heartbeat <= 1'b0;
    end else if (clear) begin
      prescale <= '0;
      seconds  <= '0;
    end else if (!freeze) begin
      if (prescale == TC) begin
        prescale  <= '0;
        seconds   <= seconds + 32'd1;
        heartbeat <= ~heartbeat;
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysid_ext_qsys.sv
// Avalon-MM system-ID slave: identity constants, scratch register, coherent
// 64-bit cycle counter snapshot and uptime seconds with heartbeat.
module sysid_ext_qsys
  import sysid_pkg::*;
#(
  parameter logic [31:0]  ID_VALUE       = 32'h0000_0000,
  parameter logic [31:0]  TIMESTAMP      = 32'd1620606931,
  parameter int unsigned  NUM_USER_WORDS = 4,
  parameter logic [255:0] USER_WORDS     = 256'h0,
  parameter int unsigned  READ_LATENCY   = 1,
  parameter int unsigned  UPTIME_DIV     = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        heartbeat
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "sysid_ext_qsys: READ_LATENCY must be 1 or 2");
  end
  if (NUM_USER_WORDS > 8) begin : g_bad_user_words
    $fatal(1, "sysid_ext_qsys: NUM_USER_WORDS must be 0..8");
  end
  if (UPTIME_DIV < 2) begin : g_bad_div
    $fatal(1, "sysid_ext_qsys: UPTIME_DIV must be at least 2");
  end

  logic [63:0] cycle_cnt;
  logic [31:0] scratch;
  logic [31:0] hi_snap;
  logic [31:0] seconds;
  logic        freeze;
  logic        wr_ctrl;
  logic        ctrl_clear;
  logic [31:0] rdata_c;
  logic        pipe_valid;
  logic [31:0] pipe_data;
  logic        out_valid;
  logic [31:0] out_data;

  assign wr_ctrl    = write && (address == ADDR_CTRL) && byteenable[0];
  assign ctrl_clear = wr_ctrl && writedata[CTRL_CLEAR_BIT];

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch <= '0;
      freeze  <= 1'b0;
    end else begin
      if (write && (address == ADDR_SCRATCH))
        scratch <= byte_merge(scratch, writedata, byteenable);
      if (wr_ctrl)
        freeze <= writedata[CTRL_FREEZE_BIT];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || ctrl_clear) cycle_cnt <= '0;
    else if (!freeze)        cycle_cnt <= cycle_cnt + 64'd1;
  end

  // High word is captured alongside the low-word read so a lo/hi read pair
  // is coherent across a carry out of bit 31.
  always_ff @(posedge clock) begin
    if (reset) hi_snap <= '0;
    else if (read && (address == ADDR_CYCLE_LO)) hi_snap <= cycle_cnt[63:32];
  end

  sysid_uptime #(.UPTIME_DIV(UPTIME_DIV)) u_uptime (
    .clock     (clock),
    .reset     (reset),
    .clear     (ctrl_clear),
    .freeze    (freeze),
    .seconds   (seconds),
    .heartbeat (heartbeat)
  );

  always_comb begin
    rdata_c = '0;
    case (address)
      ADDR_ID:        rdata_c = ID_VALUE;
      ADDR_TIMESTAMP: rdata_c = TIMESTAMP;
      ADDR_CAPS:      rdata_c = {CAPS_MAGIC, 8'(NUM_USER_WORDS), 8'(READ_LATENCY)};
      ADDR_SCRATCH:   rdata_c = scratch;
      ADDR_CYCLE_LO:  rdata_c = cycle_cnt[31:0];
      ADDR_CYCLE_HI:  rdata_c = hi_snap;
      ADDR_SECONDS:   rdata_c = seconds;
      ADDR_CTRL:      rdata_c = {30'b0, freeze, 1'b0};
      default: begin
        if (address[3] && (32'(address[2:0]) < NUM_USER_WORDS))
          rdata_c = USER_WORDS[{address[2:0], 5'd0} +: 32];
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= read;
      if (read) pipe_data <= rdata_c;
    end
  end

  always_comb begin
    out_valid = pipe_valid;
    out_data  = pipe_data;
    if (READ_LATENCY == 1) begin
      out_valid = read;
      out_data  = rdata_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdatavalid <= 1'b0;
      readdata      <= '0;
    end else begin
      readdatavalid <= out_valid;
      if (out_valid) readdata <= out_data;
    end
  end

endmodule

// File: tb/tb_sysid_ext_qsys.sv
// Self-checking bench: a latency-1 and a latency-2 instance on a shared bus,
// checked against a behavioural model of the register map and counters.
module tb_sysid_ext_qsys;

  localparam int DIV = 4;
  localparam logic [31:0] TS = 32'd1620606931;
  localparam logic [255:0] UW = {32'h8888_0007, 32'h7777_0006, 32'h6666_0005, 32'hFFFF_EEEE,
                                 32'h1357_9BDF, 32'h0BAD_F00D, 32'hCAFE_0002, 32'hA5A5_0001};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata, readdata2;
  logic        readdatavalid, readdatavalid2;
  logic        heartbeat, heartbeat2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [255:0] uw_v = UW;

  // Model state
  logic [63:0] m_cycle = '0;
  longint      m_ticks = 0;
  logic        m_hb_base = 1'b0;
  logic [31:0] m_hisnap = '0;
  logic [31:0] m_scratch = '0;
  logic        m_freeze = 1'b0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] obs_q[$];
  int          obs_cyc_q[$];
  logic [31:0] obs2_q[$];
  int          obs2_cyc_q[$];

  always #5 clock = ~clock;

  sysid_ext_qsys #(.USER_WORDS(UW), .UPTIME_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid), .heartbeat(heartbeat)
  );

  sysid_ext_qsys #(.USER_WORDS(UW), .NUM_USER_WORDS(2), .READ_LATENCY(2), .UPTIME_DIV(DIV)) dut2 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata2),
    .readdatavalid(readdatavalid2), .heartbeat(heartbeat2)
  );

  function automatic logic exp_hb();
    return m_hb_base ^ logic'((m_ticks / DIV) % 2);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0: return 32'h0;
      4'd1: return TS;
      4'd2: return 32'h5100_0401;
      4'd3: return m_scratch;
      4'd4: return m_cycle[31:0];
      4'd5: return m_hisnap;
      4'd6: return 32'(m_ticks / DIV);
      4'd7: return {30'b0, m_freeze, 1'b0};
      default: begin
        if (a < 4'd12) return uw_v[32*(int'(a)-8) +: 32];
        return 32'h0;
      end
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (cur & ~mask) | (wd & mask);
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_cycle <= '0; m_ticks <= 0; m_hb_base <= 1'b0;
      m_hisnap <= '0; m_scratch <= '0; m_freeze <= 1'b0;
    end else begin
      if (read) begin
        exp_q.push_back(model_read(address));
        exp_cyc_q.push_back(cyc + 1);
        if (address == 4'd4) m_hisnap <= m_cycle[63:32];
      end
      if (write && address == 4'd3) m_scratch <= merge(m_scratch, writedata, byteenable);
      if (write && address == 4'd7 && byteenable[0]) m_freeze <= writedata[1];
      if (write && address == 4'd7 && byteenable[0] && writedata[0]) begin
        m_cycle <= '0; m_ticks <= 0; m_hb_base <= exp_hb();
      end else if (!m_freeze) begin
        m_cycle <= m_cycle + 64'd1; m_ticks <= m_ticks + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (readdatavalid)  begin obs_q.push_back(readdata);   obs_cyc_q.push_back(cyc);  end
    if (readdatavalid2) begin obs2_q.push_back(readdata2); obs2_cyc_q.push_back(cyc); end
  end

  task automatic flush_all();
    exp_q.delete(); exp_cyc_q.delete();
    obs_q.delete(); obs_cyc_q.delete();
    obs2_q.delete(); obs2_cyc_q.delete();
  endtask

  task automatic test_reset();
    int issue[3];
    logic [31:0] e1[3];
    logic [31:0] e2[3];
    e1 = '{32'h0, TS, 32'h5100_0401};
    e2 = '{32'h0, TS, 32'h5100_0202};
    repeat (3) @(negedge clock);
    checks++;
    if (readdata !== 32'h0 || readdatavalid !== 1'b0 || heartbeat !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got rd=%h v=%b hb=%b exp 0/0/0", readdata, readdatavalid, heartbeat);
    end
    reset = 1'b0;
    @(negedge clock);
    flush_all();
    for (int i = 0; i < 3; i++) begin
      address = 4'(i); read = 1'b1; issue[i] = cyc;
      @(negedge clock);
      read = 1'b0;
      repeat (3) @(negedge clock);
    end
    checks++;
    if (obs_q.size() != 3 || obs2_q.size() != 3) begin
      errors++; $display("FAIL reset_read_count got %0d/%0d exp 3/3", obs_q.size(), obs2_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== e1[i] || obs_cyc_q[i] != issue[i] + 1) begin
          errors++; $display("FAIL lat1_read%0d got %h@%0d exp %h@%0d", i, obs_q[i], obs_cyc_q[i], e1[i], issue[i] + 1);
        end
        checks++;
        if (obs2_q[i] !== e2[i] || obs2_cyc_q[i] != issue[i] + 2) begin
          errors++; $display("FAIL lat2_read%0d got %h@%0d exp %h@%0d", i, obs2_q[i], obs2_cyc_q[i], e2[i], issue[i] + 2);
        end
      end
    end
    checks++;
    if (readdata !== 32'h5100_0401 || readdatavalid !== 1'b0) begin
      errors++; $display("FAIL readdata_hold got %h v=%b exp 51000401 v=0", readdata, readdatavalid);
    end
    flush_all();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    int c, ec;
    flush_all();
    for (int a = 0; a < 16; a++) begin
      address = 4'(a); read = 1'b1;
      @(negedge clock);
    end
    read = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (obs_q.size() != 16 || exp_q.size() != 16 || obs2_q.size() != 16) begin
      errors++; $display("FAIL b2b_count got %0d/%0d exp 16/16", obs_q.size(), obs2_q.size());
    end
    if (obs_q.size() == 16) begin
      checks++;
      if (obs_q[8] !== 32'hA5A5_0001) begin
        errors++; $display("FAIL b2b_user0 got %h exp a5a50001", obs_q[8]);
      end
      for (int i = 12; i < 16; i++) begin
        checks++;
        if (obs_q[i] !== 32'h0) begin
          errors++; $display("FAIL b2b_unmapped%0d got %h exp 0", i, obs_q[i]);
        end
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      d = obs_q.pop_front(); c = obs_cyc_q.pop_front();
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      checks++;
      if (d !== e || c != ec) begin
        errors++; $display("FAIL b2b_read got %h@%0d exp %h@%0d", d, c, e, ec);
      end
    end
    flush_all();
  endtask

  task automatic test_scratch();
    flush_all();
    address = 4'd3; write = 1'b1; writedata = 32'hDEAD_BEEF; byteenable = 4'hF;
    @(negedge clock);
    writedata = 32'h0000_0011; byteenable = 4'b0001;
    @(negedge clock);
    write = 1'b0; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'hDEAD_BE11) begin
      errors++; $display("FAIL scratch_merge got %h (n=%0d) exp deadbe11", obs_q.size() ? obs_q[0] : 32'hX, obs_q.size());
    end
    flush_all();
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    int c, ec;
    flush_all();
    for (int i = 0; i < 120; i++) begin
      read = ($urandom_range(0, 1) == 1);
      write = ($urandom_range(0, 2) == 0);
      address = 4'($urandom_range(0, 15));
      if (write && $urandom_range(0, 1) == 1) address = 4'd3;
      writedata = $urandom;
      byteenable = 4'($urandom_range(0, 15));
      @(negedge clock);
    end
    read = 1'b0;
    address = 4'd7; write = 1'b1; writedata = 32'h0; byteenable = 4'h1;
    @(negedge clock);
    write = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      d = obs_q.pop_front(); c = obs_cyc_q.pop_front();
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      checks++;
      if (d !== e || c != ec) begin
        errors++; $display("FAIL rand_read got %h@%0d exp %h@%0d", d, c, e, ec);
      end
    end
    flush_all();
  endtask

  task automatic test_snapshot();
    flush_all();
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    @(negedge clock);
    release dut.cycle_cnt;
    address = 4'd4; read = 1'b1;
    @(negedge clock);
    address = 4'd5;
    @(negedge clock);
    address = 4'd4;
    @(negedge clock);
    address = 4'd5;
    @(negedge clock);
    read = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (obs_q.size() != 4) begin
      errors++; $display("FAIL snap_count got %0d exp 4", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL snap_lo got %h exp ffffffff", obs_q[0]);
      end
      checks++;
      if (obs_q[1] !== 32'h0) begin
        errors++; $display("FAIL snap_hi got %h exp 00000000", obs_q[1]);
      end
      checks++;
      if (obs_q[3] !== 32'h1) begin
        errors++; $display("FAIL snap_hi_next got %h exp 00000001", obs_q[3]);
      end
    end
    flush_all();
  endtask

  task automatic test_uptime();
    logic prev;
    int toggles;
    logic [31:0] s_before;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    flush_all();
    toggles = 0; prev = heartbeat;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (heartbeat !== prev) toggles++;
      prev = heartbeat;
      checks++;
      if (heartbeat !== exp_hb()) begin
        errors++; $display("FAIL hb_track got %b exp %b", heartbeat, exp_hb());
      end
    end
    address = 4'd6; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    @(negedge clock);
    checks++;
    if (toggles != 3 || obs_q.size() != 1 || obs_q[0] !== 32'd3) begin
      errors++; $display("FAIL uptime_12 got sec=%h tog=%0d exp 3/3", obs_q.size() ? obs_q[0] : 32'hX, toggles);
    end
    address = 4'd7; write = 1'b1; writedata = 32'h2; byteenable = 4'h1;
    @(negedge clock);
    write = 1'b0; address = 4'd6; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    prev = heartbeat;
    repeat (20) @(negedge clock);
    checks++;
    if (heartbeat !== prev) begin
      errors++; $display("FAIL freeze_hb got %b exp %b", heartbeat, prev);
    end
    read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    address = 4'd7; write = 1'b1; writedata = 32'h0;
    @(negedge clock);
    write = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL freeze_count got %0d exp 3", obs_q.size());
    end else begin
      s_before = obs_q[1];
      checks++;
      if (obs_q[2] !== s_before || obs_q[2] !== exp_q[2]) begin
        errors++; $display("FAIL freeze_hold got %h exp %h", obs_q[2], exp_q[2]);
      end
    end
    flush_all();
  endtask

  task automatic test_clear();
    logic [31:0] d, e;
    int c, ec, guard;
    flush_all();
    guard = 0;
    while ((m_ticks % DIV) != DIV - 1 && guard < 2 * DIV) begin
      @(negedge clock);
      guard++;
    end
    checks++;
    if (guard >= 2 * DIV) begin
      errors++; $display("FAIL clear_align got timeout exp prescaler at terminal count");
    end
    address = 4'd7; write = 1'b1; writedata = 32'h1; byteenable = 4'h1;
    @(negedge clock);
    write = 1'b0; read = 1'b1;
    @(negedge clock);
    address = 4'd6;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clock);
      checks++;
      if (heartbeat !== exp_hb()) begin
        errors++; $display("FAIL clear_hb got %b exp %b", heartbeat, exp_hb());
      end
    end
    read = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (obs_q.size() != 2 * DIV + 1) begin
      errors++; $display("FAIL clear_count got %0d exp %0d", obs_q.size(), 2 * DIV + 1);
    end else begin
      checks++;
      if (obs_q[0] !== 32'h0 || obs_q[1] !== 32'h0 || obs_q[DIV-1] !== 32'h0 || obs_q[DIV] !== 32'h1) begin
        errors++; $display("FAIL clear_tc got ctrl=%h s=%h %h %h exp 0 0 0 1", obs_q[0], obs_q[1], obs_q[DIV-1], obs_q[DIV]);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      d = obs_q.pop_front(); c = obs_cyc_q.pop_front();
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      checks++;
      if (d !== e || c != ec) begin
        errors++; $display("FAIL clear_read got %h@%0d exp %h@%0d", d, c, e, ec);
      end
    end
    flush_all();
  endtask

  task automatic test_reset_flush();
    flush_all();
    address = 4'd1; read = 1'b1;
    @(negedge clock);
    read = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (obs2_q.size() != 0) begin
      errors++; $display("FAIL flush_lat2 got %0d valid pulses exp 0", obs2_q.size());
    end
    flush_all();
    address = 4'd1; read = 1'b1; reset = 1'b1;
    @(negedge clock);
    read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (obs_q.size() != 0 || readdata !== 32'h0 || heartbeat !== 1'b0) begin
      errors++; $display("FAIL flush_lat1 got n=%0d rd=%h hb=%b exp 0/0/0", obs_q.size(), readdata, heartbeat);
    end
    flush_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_scratch();
    test_random();
    test_snapshot();
    test_uptime();
    test_clear();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
